mole_round_ctrl: RTL

//  Round sequencer around the hit checker. Picks the next mole position (random_num) from
//  an LFSR and holds it stable for one round. Consumes the checker's give_point_life and
//  the raw buttons, then updates score and lives. Declares game over when lives reach 0.
//  Top level gates checker lights with mole_valid.

---
 rtl/game_pkg.sv | 17 +
 rtl/lfsr8.sv | 17 +
 rtl/mole_round_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, LFSR taps and mole count for the round controller
package game_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_ACTIVE,
    S_HIT,
    S_MISS,
    S_GAME_OVER
  } state_t;
  localparam int NUM_MOLES = 4;
  localparam int MOLE_W = $clog2(NUM_MOLES);
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/lfsr8.sv
// lfsr8: free-running 8-bit Fibonacci LFSR (taps 8,6,5,4), advances every clock
module lfsr8
  import game_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);
  logic [7:0] q_q, q_d;
  always_comb q_d = lfsr_next(q_q);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q_q <= SEED;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl: whack-a-mole round sequencer; picks the mole, times the round, keeps score and lives
module mole_round_ctrl
  import game_pkg::*;
#(
  parameter int         ROUND_CYCLES = 50_000_000,
  parameter int         GAP_CYCLES   = 12_500_000,
  parameter int         START_LIVES  = 3,
  parameter int         LIVES_W      = 2,
  parameter int         SCORE_W      = 8,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_n,
  input  logic [3:0]         buttons_n,
  input  logic               give_point_life,
  output logic [MOLE_W-1:0]  random_num,
  output logic               mole_valid,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               game_over
);
  localparam int CNT_MAX = ROUND_CYCLES > GAP_CYCLES ? ROUND_CYCLES : GAP_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX) + 1;
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MOLE_W-1:0] num_q, num_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic wrong_q, wrong_d;
  logic start_m_q, start_s_q, start_p_q, start_evt_q;
  logic [3:0] btn_m_q, btn_s_q;
  logic gpl_m_q, gpl_s_q;
  logic [7:0] lfsr_q;
  logic press, wrong_now, gap_done, round_done;
  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk(clk),
    .rst(rst),
    .q  (lfsr_q)
  );
  // idle levels on reset so a release of rst never looks like a press
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      start_m_q   <= 1'b1;
      start_s_q   <= 1'b1;
      start_p_q   <= 1'b1;
      start_evt_q <= 1'b0;
      btn_m_q     <= 4'hF;
      btn_s_q     <= 4'hF;
      gpl_m_q     <= 1'b0;
      gpl_s_q     <= 1'b0;
    end else begin
      start_m_q   <= start_n;
      start_s_q   <= start_m_q;
      start_p_q   <= start_s_q;
      start_evt_q <= start_p_q & ~start_s_q;
      btn_m_q     <= buttons_n;
      btn_s_q     <= btn_m_q;
      gpl_m_q     <= give_point_life;
      gpl_s_q     <= gpl_m_q;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      score_q <= '0;
      lives_q <= LIVES_INIT;
      wrong_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      score_q <= score_d;
      lives_q <= lives_d;
      wrong_q <= wrong_d;
    end
  always_comb begin
    press      = ~&btn_s_q;
    wrong_now  = press & ~gpl_s_q;
    gap_done   = cnt_q == CNT_W'(GAP_CYCLES - 1);
    round_done = cnt_q == CNT_W'(ROUND_CYCLES - 1);
    state_d    = state_q;
    cnt_d      = cnt_q;
    num_d      = num_q;
    score_d    = score_q;
    lives_d    = lives_q;
    wrong_d    = 1'b0;
    case (state_q)
      S_IDLE, S_GAME_OVER:
        if (start_evt_q) begin
          state_d = S_GAP;
          cnt_d   = '0;
          score_d = '0;
          lives_d = LIVES_INIT;
        end
      S_GAP: begin
        cnt_d = gap_done ? cnt_q : cnt_q + CNT_W'(1);
        if (gap_done && &btn_s_q) begin
          state_d = S_ACTIVE;
          num_d   = lfsr_q[MOLE_W-1:0];
          cnt_d   = '0;
        end
      end
      S_ACTIVE: begin
        cnt_d   = cnt_q + CNT_W'(1);
        wrong_d = wrong_now;
        if (gpl_s_q) begin
          state_d = S_HIT;
          score_d = &score_q ? score_q : score_q + SCORE_W'(1);
        end else if ((wrong_now && wrong_q) || round_done) begin
          state_d = S_MISS;
          lives_d = lives_q - LIVES_W'(1);
        end
      end
      S_HIT: begin
        state_d = S_GAP;
        cnt_d   = '0;
      end
      S_MISS: begin
        state_d = lives_q == '0 ? S_GAME_OVER : S_GAP;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    mole_valid = state_q == S_ACTIVE;
    hit_pulse  = state_q == S_HIT;
    miss_pulse = state_q == S_MISS;
    game_over  = state_q == S_GAME_OVER;
    random_num = num_q;
    score      = score_q;
    lives      = lives_q;
  end
endmodule
